// File: rtl/bg_scroll_engine.sv
// Vertical background scroller: a tick divider advances a wrapped row offset and
// each advance triggers a full-frame ROM-to-VGA sweep at the new offset.
module bg_scroll_engine #(
  parameter int unsigned XSCREEN  = 160,
  parameter int unsigned YSCREEN  = 120,
  parameter int unsigned XW       = 8,
  parameter int unsigned YW       = 7,
  parameter int unsigned AW       = 15,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned SPEED_W  = 3,
  parameter int unsigned TICK_DIV = 6250000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                enable,
  input  logic                dir,
  input  logic [SPEED_W-1:0]  speed,
  output logic [AW-1:0]       rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [XW-1:0]       x,
  output logic [YW-1:0]       y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                frame_done,
  output logic [YW-1:0]       offset
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned OW    = YW + 1;
  localparam int unsigned BW    = AW + 1;
  localparam int unsigned FRAME = XSCREEN * YSCREEN;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FLUSH, S_DONE} state_t;

  state_t          state;
  logic [CNT_W-1:0] tick_cnt;
  logic            tick_c;
  logic            pending;
  logic [AW-1:0]   off_base;
  logic [XW-1:0]   px;
  logic [YW-1:0]   py;
  logic [YW-1:0]   src_row;
  logic [AW-1:0]   row_base;
  logic [XW-1:0]   ax;
  logic [YW-1:0]   ay;
  logic            addr_v;

  logic [OW-1:0]   off_sum_c;
  logic [OW-1:0]   off_next_c;
  logic [BW-1:0]   base_step_c;
  logic [BW-1:0]   base_sum_c;
  logic [BW-1:0]   base_next_c;

  // ROM data arrives aligned with the registered pixel coordinates
  assign colour = rom_q;

  assign tick_c = enable && (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  // Next offset and its row base (offset*XSCREEN), each wrapped by one compare/subtract
  always_comb begin
    base_step_c = BW'(speed) * BW'(XSCREEN);
    off_sum_c   = '0;
    base_sum_c  = '0;
    if (!dir) begin
      off_sum_c  = OW'(offset) + OW'(speed);
      base_sum_c = BW'(off_base) + base_step_c;
    end else begin
      off_sum_c  = OW'(offset) + OW'(YSCREEN) - OW'(speed);
      base_sum_c = BW'(off_base) + BW'(FRAME) - base_step_c;
    end
    off_next_c  = (off_sum_c >= OW'(YSCREEN)) ? off_sum_c - OW'(YSCREEN) : off_sum_c;
    base_next_c = (base_sum_c >= BW'(FRAME)) ? base_sum_c - BW'(FRAME) : base_sum_c;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      offset     <= '0;
      off_base   <= '0;
      px         <= '0;
      py         <= '0;
      src_row    <= '0;
      row_base   <= '0;
      ax         <= '0;
      ay         <= '0;
      addr_v     <= 1'b0;
      rom_addr   <= '0;
      x          <= '0;
      y          <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      plot       <= addr_v;
      x          <= ax;
      y          <= ay;
      addr_v     <= 1'b0;
      frame_done <= 1'b0;

      if (tick_c) begin
        offset   <= off_next_c[YW-1:0];
        off_base <= base_next_c[AW-1:0];
      end

      case (state)
        S_IDLE: begin
          if (pending) begin
            pending  <= 1'b0;
            src_row  <= offset;
            row_base <= off_base;
            px       <= '0;
            py       <= '0;
            busy     <= 1'b1;
            state    <= S_DRAW;
          end
        end
        S_DRAW: begin
          rom_addr <= row_base + AW'(px);
          ax       <= px;
          ay       <= py;
          addr_v   <= 1'b1;
          if (px == XW'(XSCREEN - 1)) begin
            px <= '0;
            py <= py + YW'(1);
            // Source row wraps independently of the screen row
            if (src_row == YW'(YSCREEN - 1)) begin
              src_row  <= '0;
              row_base <= '0;
            end else begin
              src_row  <= src_row + YW'(1);
              row_base <= row_base + AW'(XSCREEN);
            end
            if (py == YW'(YSCREEN - 1)) begin
              state <= S_FLUSH;
            end
          end else begin
            px <= px + XW'(1);
          end
        end
        S_FLUSH: begin
          state <= S_DONE;
        end
        S_DONE: begin
          busy       <= 1'b0;
          frame_done <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // A tick always leaves a frame owed, even when one is being started now
      if (tick_c) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bg_scroll_engine.sv
// Bench for bg_scroll_engine: scripted and random ticks against an arithmetic
// offset model and a per-pixel frame model fed by a synthetic ROM.
module tb_bg_scroll_engine;

  localparam int unsigned XS = 160;
  localparam int unsigned YS = 120;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned AW = 15;
  localparam int unsigned CW = 3;
  localparam int unsigned SW = 3;
  localparam int unsigned TD = 4;

  logic          CLOCK_50 = 1'b0;
  logic          resetn   = 1'b0;
  logic          enable   = 1'b0;
  logic          dir      = 1'b0;
  logic [SW-1:0] speed    = '0;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_q    = '0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;
  logic          busy;
  logic          frame_done;
  logic [YW-1:0] offset;

  bg_scroll_engine #(
    .XSCREEN(XS), .YSCREEN(YS), .XW(XW), .YW(YW), .AW(AW),
    .COLOUR_W(CW), .SPEED_W(SW), .TICK_DIV(TD)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable), .dir(dir),
    .speed(speed), .rom_addr(rom_addr), .rom_q(rom_q), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .frame_done(frame_done),
    .offset(offset)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [CW-1:0] rom_f(input logic [AW-1:0] a);
    return a[2:0] ^ a[9:7] ^ a[14:12];
  endfunction

  // Synchronous ROM with one cycle of read latency
  always @(posedge CLOCK_50) rom_q <= rom_f(rom_addr);

  int n_cmp = 0;
  int n_bad = 0;
  int exp_off = 0;
  int exp_q[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame monitor: every plot is compared with the pixel the scroll rules predict
  int pix_idx = 0;
  int frame_errs = 0;
  int last_plots = 0;
  int last_errs = 0;
  int fd_count = 0;
  int cur_off = 0;
  int first_x = -1;
  int first_y = -1;
  int row_addr[4];
  int ex, ey, ea;
  logic [AW-1:0] addr_d = '0;

  always @(negedge CLOCK_50) begin
    if (!resetn) begin
      pix_idx    = 0;
      frame_errs = 0;
      addr_d     = '0;
    end else begin
      if (plot) begin
        if (pix_idx == 0) begin
          if (exp_q.size() > 0) cur_off = exp_q.pop_front();
          else begin
            cur_off = 0;
            frame_errs++;
          end
          first_x = int'(x);
          first_y = int'(y);
        end
        ex = pix_idx % XS;
        ey = pix_idx / XS;
        ea = ((cur_off + ey) % YS) * XS + ex;
        if (ex == 0 && ey < 4) row_addr[ey] = int'(addr_d);
        if (int'(x) != ex || int'(y) != ey || int'(addr_d) != ea ||
            colour != rom_f(AW'(ea)) || !busy)
          frame_errs++;
        pix_idx++;
      end
      if (frame_done) begin
        last_plots = pix_idx;
        last_errs  = frame_errs;
        fd_count++;
        pix_idx    = 0;
        frame_errs = 0;
      end
      addr_d = rom_addr;
    end
  end

  // One tick: enable for exactly TICK_DIV cycles; offset must move only on the last
  task automatic do_tick(input int s, input int d, input bit push);
    int nxt;
    speed  = SW'(s);
    dir    = d[0];
    enable = 1'b1;
    nxt = d[0] ? (exp_off - s + YS) % YS : (exp_off + s) % YS;
    for (int i = 0; i < TD; i++) begin
      @(posedge CLOCK_50); #1;
      if (i == TD - 1) check_eq("tick_off", int'(offset), nxt);
      else             check_eq("pre_tick_off", int'(offset), exp_off);
    end
    enable  = 1'b0;
    exp_off = nxt;
    if (push) exp_q.push_back(exp_off);
  endtask

  task automatic wait_done(input int lim);
    int seen;
    seen = 0;
    for (int i = 0; i < lim && seen == 0; i++) begin
      @(posedge CLOCK_50); #1;
      if (frame_done) begin
        seen = 1;
        check_eq("done_busy", int'(busy), 0);
      end
    end
    check_eq("done_wait", seen, 1);
    @(negedge CLOCK_50); #1;
  endtask

  task automatic wait_pix(input int n);
    int ok;
    ok = 0;
    for (int i = 0; i < 30000 && ok == 0; i++) begin
      @(posedge CLOCK_50); #1;
      if (pix_idx >= n) ok = 1;
    end
    check_eq("pix_wait", ok, 1);
  endtask

  task automatic hit_reset();
    int fd_before;
    fd_before = fd_count;
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_plot", int'(plot), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_offset", int'(offset), 0);
    check_eq("rst_addr", int'(rom_addr), 0);
    exp_off = 0;
    repeat (3) @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_eq("rst_no_done", fd_count, fd_before);
    check_eq("rst_idle_plot", int'(plot), 0);
  endtask

  initial begin
    repeat (3) @(posedge CLOCK_50);
    #1 resetn = 1'b1;

    // Disabled after reset: nothing moves
    for (int i = 0; i < 100; i++) begin
      @(posedge CLOCK_50); #1;
      check_eq("idle_plot", int'(plot), 0);
      check_eq("idle_busy", int'(busy), 0);
      check_eq("idle_offset", int'(offset), 0);
      check_eq("idle_addr", int'(rom_addr), 0);
    end

    // Single +1 tick, one full frame at offset 1
    do_tick(1, 0, 1'b1);
    wait_done(25000);
    check_eq("f1_plots", last_plots, XS * YS);
    check_eq("f1_errs", last_errs, 0);
    check_eq("f1_first_x", first_x, 0);
    check_eq("f1_first_y", first_y, 0);
    check_eq("f1_row0_addr", row_addr[0], 160);

    // Two ticks mid-sweep coalesce into exactly one follow-up frame at +6
    do_tick(3, 0, 1'b1);
    wait_pix(2000);
    do_tick(3, 0, 1'b0);
    wait_pix(6000);
    do_tick(3, 0, 1'b1);
    wait_done(25000);
    check_eq("f2_plots", last_plots, XS * YS);
    check_eq("f2_errs", last_errs, 0);
    @(posedge CLOCK_50); #1;
    check_eq("f3_starts", int'(busy), 1);
    wait_done(25000);
    check_eq("f3_plots", last_plots, XS * YS);
    check_eq("f3_errs", last_errs, 0);
    check_eq("f3_row0_addr", row_addr[0], 10 * XS);
    repeat (50) @(posedge CLOCK_50);
    #1;
    check_eq("no_extra_busy", int'(busy), 0);
    check_eq("no_extra_pix", pix_idx, 0);
    check_eq("frames_total", fd_count, 3);
    hit_reset();

    // Downward wrap 0 -> 118, then reset partway through the frame
    do_tick(2, 1, 1'b1);
    wait_pix(5000);
    check_eq("dn_errs", frame_errs, 0);
    check_eq("dn_row0_addr", row_addr[0], 18880);
    check_eq("dn_row2_addr", row_addr[2], 0);
    hit_reset();

    // Clean frame after reset at offset 119; +1 tick mid-frame wraps to 0
    do_tick(1, 1, 1'b1);
    wait_pix(400);
    do_tick(1, 0, 1'b0);
    check_eq("wrap_zero", int'(offset), 0);
    wait_pix(600);
    check_eq("w_errs", frame_errs, 0);
    check_eq("w_first_x", first_x, 0);
    check_eq("w_first_y", first_y, 0);
    check_eq("w_row0_addr", row_addr[0], 119 * XS);
    check_eq("w_row1_addr", row_addr[1], 0);
    hit_reset();

    // Random speeds and directions, ticks both idle and mid-frame
    do_tick(int'($urandom_range(7, 0)), int'($urandom_range(1, 0)), 1'b1);
    for (int i = 0; i < 8; i++)
      do_tick(int'($urandom_range(7, 0)), int'($urandom_range(1, 0)), 1'b0);
    wait_pix(1500);
    check_eq("rnd_errs", frame_errs, 0);
    check_eq("rnd_first_x", first_x, 0);
    check_eq("rnd_first_y", first_y, 0);
    hit_reset();

    check_eq("final_frames", fd_count, 3);
    check_eq("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
